// File: rtl/serial_adder_ctrl_pkg.sv
// Shared definitions for the bit-serial adder controller: FSM encoding and
// parameter helpers used at elaboration time.
package serial_adder_ctrl_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    StIdle = ST_IDLE,
    StRun  = ST_RUN,
    StDone = ST_DONE
  } state_e;

  function automatic bit width_ok(int unsigned w);
    return (w >= 1) && (w <= 32);
  endfunction

  // Bit counter never narrower than one bit, even for a 1-bit adder.
  function automatic int unsigned cnt_width(int unsigned w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/half_adder_flux.sv
// Single-bit half adder.
module half_adder_flux (
  input  logic a,
  input  logic b,
  output logic sum,
  output logic carry
);

  assign sum   = a ^ b;
  assign carry = a & b;

endmodule

// File: rtl/serial_fa_cell.sv
// Combinational full-adder cell: two cascaded half adders with OR-merged carries.
module serial_fa_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  logic s0, c0, c1;

  half_adder_flux u_ha0 (
    .a     (a),
    .b     (b),
    .sum   (s0),
    .carry (c0)
  );

  half_adder_flux u_ha1 (
    .a     (s0),
    .b     (cin),
    .sum   (sum),
    .carry (c1)
  );

  assign cout = c0 | c1;

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: adds a + b + cin one bit per clock, LSB first,
// with a start/busy/done handshake and registered sum/cout.
module serial_adder_ctrl
  import serial_adder_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int unsigned CntW = cnt_width(WIDTH);

  if (!width_ok(WIDTH)) begin : g_bad_width
    $error("serial_adder_ctrl: WIDTH must be in 1..32");
  end

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d, b_sh_q, b_sh_d, s_sh_q, s_sh_d, s_next;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             c_q, c_d, busy_q, busy_d, done_q, done_d, cout_q, cout_d;
  logic             s_bit, c_bit;

  serial_fa_cell u_fa (
    .a    (a_sh_q[0]),
    .b    (b_sh_q[0]),
    .cin  (c_q),
    .sum  (s_bit),
    .cout (c_bit)
  );

  // New sum bit enters at the MSB so the LSB lands at bit 0 after WIDTH shifts.
  always_comb begin
    s_next            = s_sh_q >> 1;
    s_next[WIDTH-1]   = s_bit;
  end

  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    s_sh_d  = s_sh_q;
    c_d     = c_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      StIdle, StDone: begin
        if (start) begin
          a_sh_d  = a;
          b_sh_d  = b;
          c_d     = cin;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = StRun;
        end else begin
          state_d = StIdle;
        end
      end
      StRun: begin
        a_sh_d = a_sh_q >> 1;
        b_sh_d = b_sh_q >> 1;
        s_sh_d = s_next;
        c_d    = c_bit;
        cnt_d  = cnt_q + CntW'(1);
        busy_d = 1'b1;
        if (cnt_q == CntW'(WIDTH - 1)) begin
          sum_d   = s_next;
          cout_d  = c_bit;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = StDone;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      s_sh_q  <= '0;
      c_q     <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      s_sh_q  <= s_sh_d;
      c_q     <= c_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule
